// File: rtl/alu_seq_16b.sv
// ---------------------------------------------------------------------------
// alu_seq_16b
//
// Runs a 16-bit arithmetic/logic operation through an external 8-bit ALU in
// two passes. The low byte goes first and the high byte second. Carry or
// borrow is chained from the low pass into the high pass.
//
// Ports
//   clk, rst_n             clock (rising edge), synchronous active-low reset
//   in_valid / in_ready    request handshake; op, a16, b16, ci_in are sampled
//                          only on the accepting edge
//   res_valid / res_ready  result handshake; result, co_out, zo_out, err are
//                          held while res_valid=1 and res_ready=0
//   alu_a/alu_b/alu_s/     drive the 8-bit ALU; outside a pass these sit at
//   alu_ci                 0 / IDLE_S / 0
//   alu_out/alu_co/alu_zo  ALU response, captured at the end of each pass
// ---------------------------------------------------------------------------
module alu_seq_16b #(
  parameter logic [3:0] IDLE_S = 4'b1010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  input  logic        ci_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result,
  output logic        co_out,
  output logic        zo_out,
  output logic        err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_s,
  output logic        alu_ci,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  input  logic        alu_zo
);

  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SBC = 4'b0111;
  localparam logic [3:0] OP_1C  = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_OR  = 4'b1011;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_INC = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  op_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic        ci_reg;
  logic [7:0]  lo_reg;
  logic [7:0]  hi_reg;
  logic        c_lo_reg;
  logic        z_lo_reg;
  logic        co_reg;
  logic        zo_reg;
  logic        err_reg;

  function automatic logic is_supported(input logic [3:0] o);
    case (o)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC,
      OP_1C, OP_AND, OP_OR, OP_XOR, OP_INC: is_supported = 1'b1;
      default:                              is_supported = 1'b0;
    endcase
  endfunction

  // Logic ops carry no arithmetic: ci_in passes through both passes and
  // becomes the final carry.
  function automatic logic is_logic(input logic [3:0] o);
    case (o)
      OP_1C, OP_AND, OP_OR, OP_XOR: is_logic = 1'b1;
      default:                      is_logic = 1'b0;
    endcase
  endfunction

  // The high pass must continue the chain. ADD and INC become ADC, and SUB
  // becomes SBC, so the low-pass carry or borrow is consumed.
  function automatic logic [3:0] hi_select(input logic [3:0] o);
    case (o)
      OP_ADD:  hi_select = OP_ADC;
      OP_SUB:  hi_select = OP_SBC;
      OP_INC:  hi_select = OP_ADC;
      default: hi_select = o;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = is_supported(op) ? ST_LO : ST_DONE;
        end
      end
      ST_LO:   state_next = ST_HI;
      ST_HI:   state_next = ST_DONE;
      ST_DONE: begin
        if (res_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath. The request is latched once at acceptance. The per-pass ALU
  // response is then captured on the edge that ends each pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg   <= 4'h0;
      a_reg    <= 16'h0000;
      b_reg    <= 16'h0000;
      ci_reg   <= 1'b0;
      lo_reg   <= 8'h00;
      hi_reg   <= 8'h00;
      c_lo_reg <= 1'b0;
      z_lo_reg <= 1'b0;
      co_reg   <= 1'b0;
      zo_reg   <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            op_reg   <= op;
            a_reg    <= a16;
            b_reg    <= b16;
            ci_reg   <= ci_in;
            lo_reg   <= 8'h00;
            hi_reg   <= 8'h00;
            c_lo_reg <= 1'b0;
            z_lo_reg <= 1'b0;
            co_reg   <= 1'b0;
            zo_reg   <= 1'b0;
            err_reg  <= ~is_supported(op);
          end
        end
        ST_LO: begin
          lo_reg   <= alu_out;
          c_lo_reg <= alu_co;
          z_lo_reg <= alu_zo;
        end
        ST_HI: begin
          hi_reg <= alu_out;
          co_reg <= is_logic(op_reg) ? ci_reg : alu_co;
          zo_reg <= z_lo_reg & alu_zo;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_reg == ST_IDLE);
    res_valid = (state_reg == ST_DONE);
    result    = {hi_reg, lo_reg};
    co_out    = co_reg;
    zo_out    = zo_reg;
    err       = err_reg;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_s     = IDLE_S;
    alu_ci    = 1'b0;
    case (state_reg)
      ST_LO: begin
        alu_a  = a_reg[7:0];
        alu_b  = b_reg[7:0];
        alu_s  = op_reg;
        alu_ci = ci_reg;
      end
      ST_HI: begin
        alu_a  = a_reg[15:8];
        // INC adds only the low-pass carry into the high byte.
        alu_b  = (op_reg == OP_INC) ? 8'h00 : b_reg[15:8];
        alu_s  = hi_select(op_reg);
        alu_ci = is_logic(op_reg) ? ci_reg : c_lo_reg;
      end
      default: begin
      end
    endcase
  end

endmodule
